// File: rtl/npu_mac_sequencer.sv
// rtl/npu_mac_sequencer.sv - operand FIFO, serial MAC core sequencer and saturating dot-product reducer
module npu_mac_sequencer #(
    parameter int DEPTH   = 4,
    parameter int VEC_LEN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [3:0] i_in_act,
    input  logic [3:0] i_in_wgt,
    output logic       o_core_start,
    output logic [3:0] o_core_input,
    output logic [3:0] o_core_weight,
    input  logic [3:0] i_core_result,
    input  logic       i_core_done,
    output logic       o_out_valid,
    input  logic       i_out_ready,
    output logic [7:0] o_out_sum
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [3:0]  LAST_IDX = 4'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [3:0]    r_core_input;
    logic [3:0]    r_core_weight;
    logic          r_done_q;
    logic [7:0]    r_acc;
    logic [3:0]    r_cnt;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_done_rise;
    logic          w_accum;
    logic [8:0]    w_sum9;
    logic [7:0]    w_acc_next;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_push      = i_in_valid && !w_full;
    // A pop is exactly the IDLE->ISSUE transition, so operands load only there.
    assign w_pop       = (r_state == S_IDLE) && !w_empty;
    assign w_done_rise = i_core_done && !r_done_q;
    assign w_accum     = (r_state == S_WAIT) && w_done_rise;
    assign w_sum9      = {1'b0, r_acc} + {5'b0, i_core_result};
    assign w_acc_next  = w_sum9[8] ? 8'hFF : w_sum9[7:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_in_act, i_in_wgt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (w_done_rise) begin
                    w_next = (r_cnt == LAST_IDX) ? S_OUT : S_IDLE;
                end
            end
            S_OUT:   if (i_out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // done_q tracks core_done every cycle so a level held over from the last operation never looks like a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q      <= 1'b0;
            r_core_input  <= '0;
            r_core_weight <= '0;
            r_acc         <= '0;
            r_cnt         <= '0;
        end else begin
            r_done_q <= i_core_done;
            if (w_pop) begin
                r_core_input  <= r_mem[r_rptr][7:4];
                r_core_weight <= r_mem[r_rptr][3:0];
            end
            if (w_accum) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 1'b1;
            end else if ((r_state == S_OUT) && i_out_ready) begin
                r_acc <= '0;
                r_cnt <= '0;
            end
        end
    end

    assign o_in_ready    = !w_full;
    assign o_core_start  = (r_state == S_ISSUE);
    assign o_core_input  = r_core_input;
    assign o_core_weight = r_core_weight;
    assign o_out_valid   = (r_state == S_OUT);
    assign o_out_sum     = r_acc;

endmodule

// File: tb/tb_npu_mac_sequencer.sv
// tb/tb_npu_mac_sequencer.sv - self-checking bench for npu_mac_sequencer with behavioural serial MAC cores
module tb_npu_mac_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       hold_mode;
    logic       in_valid    [2];
    logic       in_ready    [2];
    logic [3:0] in_act      [2];
    logic [3:0] in_wgt      [2];
    logic       core_start  [2];
    logic [3:0] core_input  [2];
    logic [3:0] core_weight [2];
    logic       out_valid   [2];
    logic       out_ready   [2];
    logic [7:0] out_sum     [2];

    typedef struct {
        logic [3:0] a;
        logic [3:0] w;
    } pair_t;

    typedef struct {
        logic [31:0] pairs;
        int          exp_sum;
        logic        hold;
    } row_t;

    int    n_vec = 0;
    int    n_err = 0;
    pair_t q_exp [$];
    int    q_sum [$];
    pair_t mp;
    int    m_acc = 0;
    int    m_cnt = 0;
    int    n_start0 = 0;
    int    n_out0 = 0;
    int    n_push0 = 0;
    int    last_sum0 = -1;
    int    n_out1 = 0;
    int    sum1_a = -1;
    int    sum1_b = -1;
    int    base, np, st, s, t, stable_ok, es;
    row_t  rows [6];

    function automatic int psat(input int a, input int w);
        return (a * w > 15) ? 15 : a * w;
    endfunction

    // Serial MAC core stand-in: done rises 6 cycles after start is sampled.
    // hold_mode=0: done stays high until the next start; hold_mode=1: done is high for 5 cycles only.
    for (genvar g = 0; g < 2; g++) begin : gen
        localparam int VL = (g == 0) ? 4 : 16;
        logic       c_done;
        logic [3:0] c_result;
        logic       c_busy;
        logic [2:0] c_ctr;
        logic [2:0] c_hold;
        logic [3:0] c_a;
        logic [3:0] c_w;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                c_done   <= 1'b0;
                c_result <= '0;
                c_busy   <= 1'b0;
                c_ctr    <= '0;
                c_hold   <= '0;
                c_a      <= '0;
                c_w      <= '0;
            end else begin
                if (c_done && hold_mode) begin
                    if (c_hold == 3'd0) c_done <= 1'b0;
                    else                c_hold <= c_hold - 1'b1;
                end
                if (core_start[g]) begin
                    c_a    <= core_input[g];
                    c_w    <= core_weight[g];
                    c_busy <= 1'b1;
                    c_ctr  <= 3'd5;
                    if (!hold_mode) c_done <= 1'b0;
                end else if (c_busy) begin
                    if (c_ctr == 3'd0) begin
                        c_busy   <= 1'b0;
                        c_done   <= 1'b1;
                        c_hold   <= 3'd4;
                        c_result <= 4'(psat(int'(c_a), int'(c_w)));
                    end else begin
                        c_ctr <= c_ctr - 1'b1;
                    end
                end
            end
        end

        npu_mac_sequencer #(.DEPTH(4), .VEC_LEN(VL)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_in_valid    (in_valid[g]),
            .o_in_ready    (in_ready[g]),
            .i_in_act      (in_act[g]),
            .i_in_wgt      (in_wgt[g]),
            .o_core_start  (core_start[g]),
            .o_core_input  (core_input[g]),
            .o_core_weight (core_weight[g]),
            .i_core_result (c_result),
            .i_core_done   (c_done),
            .o_out_valid   (out_valid[g]),
            .i_out_ready   (out_ready[g]),
            .o_out_sum     (out_sum[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [3:0] a, input logic [3:0] w);
        int    tt;
        logic  rdy;
        pair_t p;
        in_valid[k] = 1'b1;
        in_act[k]   = a;
        in_wgt[k]   = w;
        tt = 0;
        forever begin
            rdy = in_ready[k];
            @(posedge clk);
            #1;
            if (rdy) break;
            tt++;
            if (tt > 3000) begin
                check("push_timeout", rdy, 1);
                break;
            end
        end
        if (rdy && k == 0) begin
            p.a = a;
            p.w = w;
            q_exp.push_back(p);
            n_push0++;
        end
    endtask

    task automatic wait_out0(input int target, input string name);
        int tt;
        tt = 0;
        while (n_out0 < target) begin
            @(posedge clk);
            #1;
            tt++;
            if (tt > 3000) begin
                check(name, n_out0, target);
                break;
            end
        end
    endtask

    task automatic push_row(input logic [31:0] pv);
        for (int j = 0; j < 4; j++) begin
            push(0, pv[31-8*j -: 4], pv[27-8*j -: 4]);
        end
        in_valid[0] = 1'b0;
    endtask

    initial begin
        rows[0] = '{32'h3215_4409, 26, 1'b0};
        rows[1] = '{32'h2323_2323, 24, 1'b1};
        rows[2] = '{32'hFFFF_FFFF, 60, 1'b0};
        rows[3] = '{32'h0000_0000, 0,  1'b1};
        rows[4] = '{32'h7271_1E12, 37, 1'b0};
        rows[5] = '{32'h4400_5311, 31, 1'b1};

        rst_n     = 1'b0;
        hold_mode = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_act[k]    = '0;
            in_wgt[k]    = '0;
            out_ready[k] = 1'b1;
        end

        // Scoreboard: issued operands must follow push order; each group of 4 products forms one expected sum.
        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (core_start[0]) begin
                        n_start0++;
                        if (q_exp.size() == 0) begin
                            check("spurious_start", core_start[0], 0);
                        end else begin
                            mp = q_exp.pop_front();
                            check("core_input_order", core_input[0], mp.a);
                            check("core_weight_order", core_weight[0], mp.w);
                            m_acc = m_acc + psat(int'(mp.a), int'(mp.w));
                            if (m_acc > 255) m_acc = 255;
                            m_cnt++;
                            if (m_cnt == 4) begin
                                q_sum.push_back(m_acc);
                                m_acc = 0;
                                m_cnt = 0;
                            end
                        end
                    end
                    if (out_valid[0] && out_ready[0]) begin
                        n_out0++;
                        last_sum0 = int'(out_sum[0]);
                        if (q_sum.size() == 0) begin
                            check("spurious_out", out_valid[0], 0);
                        end else begin
                            es = q_sum.pop_front();
                            check("out_sum_model", out_sum[0], es);
                        end
                    end
                    if (out_valid[1] && out_ready[1]) begin
                        if (n_out1 == 0) sum1_a = int'(out_sum[1]);
                        else if (n_out1 == 1) sum1_b = int'(out_sum[1]);
                        n_out1++;
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready[0], 1);
        check("rst_core_start", core_start[0], 0);
        check("rst_core_input", core_input[0], 0);
        check("rst_core_weight", core_weight[0], 0);
        check("rst_out_valid", out_valid[0], 0);
        check("rst_out_sum", out_sum[0], 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int r = 0; r < 6; r++) begin
            hold_mode = rows[r].hold;
            base = n_out0;
            push_row(rows[r].pairs);
            wait_out0(base + 1, "table_timeout");
            check("table_sum", last_sum0, rows[r].exp_sum);
        end

        // Output backpressure while the FIFO fills behind it.
        hold_mode    = 1'b0;
        out_ready[0] = 1'b0;
        base = n_out0;
        push_row(32'h2233_1451);
        t = 0;
        while (!out_valid[0] && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("hold_out_valid_seen", out_valid[0], 1);
        s  = int'(out_sum[0]);
        st = n_start0;
        np = n_push0;
        stable_ok = 1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    push(0, 4'(i + 1), 4'(i + 2));
                end
                in_valid[0] = 1'b0;
            end
            begin
                repeat (20) begin
                    @(negedge clk);
                    if (out_valid[0] !== 1'b1 || int'(out_sum[0]) != s) stable_ok = 0;
                end
                check("out_held_stable", stable_ok, 1);
                check("out_sum_held", s, 22);
                check("in_ready_full", in_ready[0], 0);
                check("accepted_while_full", n_push0 - np, 4);
                check("no_start_in_out", n_start0 - st, 0);
                @(posedge clk);
                #1;
                out_ready[0] = 1'b1;
            end
        join
        check("accepted_total", n_push0 - np, 6);
        push(0, 4'd9, 4'd1);
        push(0, 4'd2, 4'd7);
        in_valid[0] = 1'b0;
        wait_out0(base + 3, "hold_drain_timeout");

        // Randomised traffic with random output backpressure.
        hold_mode = 1'($urandom_range(0, 1));
        base = n_out0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    push(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid[0] = 1'b0;
                        repeat ($urandom_range(1, 3)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                in_valid[0] = 1'b0;
            end
            begin
                repeat (300) begin
                    out_ready[0] = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready[0] = 1'b1;
            end
        join
        wait_out0(base + 6, "random_timeout");

        // Reset while the core is busy and three pairs sit in the FIFO.
        hold_mode = 1'b0;
        st = n_start0;
        push_row(32'h1111_1111);
        t = 0;
        while (n_start0 == st && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("reset_test_start_seen", n_start0 > st, 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready[0], 1);
        check("mid_rst_core_start", core_start[0], 0);
        check("mid_rst_core_input", core_input[0], 0);
        check("mid_rst_core_weight", core_weight[0], 0);
        check("mid_rst_out_valid", out_valid[0], 0);
        check("mid_rst_out_sum", out_sum[0], 0);
        q_exp.delete();
        q_sum.delete();
        m_acc = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        st = n_start0;
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("no_start_after_reset", n_start0 - st, 0);
        base = n_out0;
        push_row(32'h3215_4409);
        wait_out0(base + 1, "post_reset_timeout");
        check("post_reset_sum", last_sum0, 26);

        // VEC_LEN=16 instance: two vectors of (15,15) give 240 each.
        for (int i = 0; i < 32; i++) begin
            push(1, 4'd15, 4'd15);
        end
        in_valid[1] = 1'b0;
        t = 0;
        while (n_out1 < 2 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("vec16_count", n_out1, 2);
        check("vec16_sum0", sum1_a, 240);
        check("vec16_sum1", sum1_b, 240);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/npu_mac_sequencer.md
# npu_mac_sequencer

Upstream feeder and reduction stage for the 4-bit serial MAC core, which multiplies one activation nibble by one weight nibble and saturates the product to 4 bits. It accepts (activation, weight) nibble pairs over a valid/ready stream and buffers them in a small FIFO. It issues each pair to the core with a start pulse, holding the operands stable for the whole multiply. It sums VEC_LEN core results into a saturating dot-product, then presents the sum on a valid/ready output.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, 2..16.
- VEC_LEN, 4: core results summed per output; 1..16.
- Reset: rst_n, asynchronous, active-low. Clock: clk.
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO not full.
- in_act  input  4  activation nibble.
- in_wgt  input  4  weight nibble.
- core_start  output  1  one-cycle start pulse to the MAC core.
- core_input  output  4  activation to the core; registered, held stable.
- core_weight  output  4  weight to the core; registered, held stable.
- core_result  input  4  core product, saturated to 0..15.
- core_done  input  1  core done flag; a level that may stay high between operations.
- out_valid  output  1  dot-product valid.
- out_ready  input  1  downstream accepts.
- out_sum  output  8  saturating sum of VEC_LEN results.

## Operation
- FIFO
  - Push when in_valid && in_ready.
  - in_ready = !full, combinational from the registered occupancy count.
  - Pop only on the IDLE->ISSUE transition.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Data order is preserved.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, OUT.
  - IDLE: if the FIFO is non-empty, load core_input/core_weight from the FIFO head, pop, and go to ISSUE. Otherwise stay.
  - ISSUE: core_start=1 for exactly this cycle. Go to WAIT unconditionally.
  - WAIT: wait for a rising edge of core_done, detected as core_done && !done_q, with done_q a registered copy of core_done.
    - On the edge: acc <= sat255(acc + core_result) and cnt <= cnt+1.
    - If cnt == VEC_LEN-1, go to OUT; otherwise go to IDLE.
    - A core_done level left high from the previous operation is never counted twice.
  - OUT: out_valid=1, out_sum=acc, held stable until out_ready.
    - On out_valid && out_ready: acc<=0, cnt<=0, go to IDLE.
    - The FIFO keeps accepting pushes while in OUT.
- core_input/core_weight change only on the IDLE->ISSUE transition. They stay constant from ISSUE through the rising edge of core_done.
- Arithmetic
  - acc is 8 bits; cnt is 4 bits.
  - Addition is done at 9 bits and clamped to 255. This is unreachable for VEC_LEN<=16 but is required.
- No timeout. A core that never raises done stalls the block in WAIT.

## Timing
- Reset values:
  - in_ready=1, core_start=0, core_input=0, core_weight=0, out_valid=0, out_sum=0.
  - FIFO empty, acc=0, cnt=0, done_q=0, state IDLE.
- Reset mid-operation:
  - All state clears immediately and FIFO contents are discarded.
  - Any core operation in flight is abandoned; the core shares rst_n.
- Pair pushed at edge E into an empty FIFO in IDLE:
  - IDLE->ISSUE at edge E+1.
  - core_start high in cycle E+1..E+2.
- With the serial core, done rises 6 cycles after the core samples start.
  - Issue-to-accumulate is 8 cycles; the per-pair cycle is about 9 cycles including IDLE.
- out_valid rises the cycle after the edge that accumulates the final result.
- Minimum one IDLE cycle between successive starts. A back-to-back start is never issued while the core is still finishing.
- in_ready deasserts the cycle after occupancy reaches DEPTH. It reasserts the cycle after a pop.

## Test plan
- Bench instantiates the real MAC core. Pairs (3,2),(1,5),(4,4),(0,9), VEC_LEN=4 -> products 6,5,15 (16 saturated by the core),0 -> out_valid with out_sum=26 (0x1A).
- Push 6 pairs back-to-back with DEPTH=4 -> in_ready low after 4 accepted. Cumulatively 6 accepted, with no loss or reorder: the resulting core_input sequence matches the push order.
- Hold out_ready=0 for 20 cycles in OUT -> out_valid and out_sum stable. FIFO fills and no new core_start occurs. Release -> acc clears and the next vector starts.
- Two vectors of all (15,15), VEC_LEN=16 -> out_sum=240 each; no saturation at 255.
- Bench core model holds core_done high for 5 cycles after each result -> each result accumulated exactly once. (2,3)x4 -> out_sum=24.
- Assert rst_n low during WAIT with 3 pairs buffered -> all outputs at reset values next cycle. After release, no core_start until new pairs are pushed.
